tristate_buffer: RTL and testbench

- N-bit tristate bus driver: drives input word `a` onto `out` while `en` is high, otherwise releases `out` to high impedance.
- Data path `a`→`out` is combinational, with zero clock latency.
- A small clocked status section records drive activity for bus-arbitration and debug logic.
- Used wherever several sources share one N-bit bus.

---
 rtl/tristate_buffer.sv | 67 ++++++
 tb/tb_tristate_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tristate_buffer.sv
// tristate_buffer
//   N-bit tristate bus driver with a small clocked status section.
//   The data path a -> out is purely combinational (zero latency); the
//   status registers record drive activity for arbitration/debug logic.
//
//   Optional build macro: TRISTATE_BUFFER_KEEPER_EN
//     When defined, a released bus (en = 0, rst = 0) is held at last_val
//     instead of floating. During rst the bus is always released.
//
// Parameters
//   N   data/bus width in bits (>= 1)
//   CW  drive-cycle counter width (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset; also releases the bus at once
//   a          data word to drive
//   en         output enable, active-high
//   out        shared bus: a when driven, all-Z when released
//   drive_q    registered copy of the enable
//   last_val   last word actually driven onto the bus
//   drive_cnt  number of driven clock cycles, saturating at all-ones
module tristate_buffer #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  a,
  input  logic          en,
  output tri   [N-1:0]  out,
  output logic          drive_q,
  output logic [N-1:0]  last_val,
  output logic [CW-1:0] drive_cnt
);

  // Reset gates the enable combinationally so the bus is released the
  // instant rst rises, without waiting for a clock edge. An X on en is
  // deliberately not filtered: it propagates to out.
  logic eff_en;
  assign eff_en = en & ~rst;

`ifdef TRISTATE_BUFFER_KEEPER_EN
  // Keeper: hold the last driven word while released, float only in reset.
  assign out = rst    ? {N{1'bz}} :
               eff_en ? a         : last_val;
`else
  assign out = eff_en ? a : {N{1'bz}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_q   <= 1'b0;
      last_val  <= '0;
      drive_cnt <= '0;
    end else begin
      drive_q <= en;
      if (en) begin
        last_val <= a;
        // Saturate rather than wrap so a long-held bus never reads as idle.
        if (drive_cnt != {CW{1'b1}})
          drive_cnt <= drive_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tristate_buffer.sv
module tb_tristate_buffer;
  localparam int N   = 8;
  localparam int CW  = 16;
  localparam int CWS = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] a;
  logic en;

  tri   [N-1:0]   bus;
  tri   [N-1:0]   bus_s;
  logic           drive_q, drive_q_s;
  logic [N-1:0]   last_val, last_val_s;
  logic [CW-1:0]  drive_cnt;
  logic [CWS-1:0] drive_cnt_s;

  // Bench-side contender used to prove the DUT has released the bus: with
  // the DUT released, the bus must follow whatever the probe drives.
  logic         probe_en  = 1'b0;
  logic [N-1:0] probe_val = '0;
  assign bus = probe_en ? probe_val : {N{1'bz}};

  int n_chk  = 0;
  int n_fail = 0;

  tristate_buffer #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .en(en), .out(bus),
    .drive_q(drive_q), .last_val(last_val), .drive_cnt(drive_cnt)
  );

  // Narrow counter instance to reach saturation quickly.
  tristate_buffer #(.N(N), .CW(CWS)) dut_s (
    .clk(clk), .rst(rst), .a(a), .en(en), .out(bus_s),
    .drive_q(drive_q_s), .last_val(last_val_s), .drive_cnt(drive_cnt_s)
  );

  always #10 clk = ~clk;

  // Reference model: count of enabled cycles (unbounded), last enabled word,
  // previous enable. Saturation is applied only when comparing.
  int unsigned  m_cnt;
  logic [N-1:0] m_last;
  logic         m_drv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_last <= '0;
      m_drv  <= 1'b0;
    end else begin
      m_drv <= en;
      if (en) begin
        m_cnt  <= m_cnt + 1;
        m_last <= a;
      end
    end
  end

  function automatic int unsigned sat(int unsigned c, int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus check: takes two time units.
  task automatic chk_bus(string name);
    logic [N-1:0] v;
    if (!rst && en === 1'b1) begin
      #1 chk({name, "_drv"}, {24'd0, bus}, {24'd0, a});
      #1;
    end else begin
`ifdef TRISTATE_BUFFER_KEEPER_EN
      if (!rst) begin
        #1 chk({name, "_keep"}, {24'd0, bus}, {24'd0, m_last});
        #1;
      end else
`endif
      begin
        v = N'($urandom);
        probe_val = v;  probe_en = 1'b1;
        #1 chk({name, "_relA"}, {24'd0, bus}, {24'd0, v});
        probe_val = ~v;
        #1 chk({name, "_relB"}, {24'd0, bus}, {24'd0, ~v});
        probe_en = 1'b0;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("drive_q",     {31'd0, drive_q},     {31'd0, m_drv});
    chk("last_val",    {24'd0, last_val},    {24'd0, m_last});
    chk("drive_cnt",   {16'd0, drive_cnt},   sat(m_cnt, CW));
    chk("drive_q_s",   {31'd0, drive_q_s},   {31'd0, m_drv});
    chk("last_val_s",  {24'd0, last_val_s},  {24'd0, m_last});
    chk("drive_cnt_s", {30'd0, drive_cnt_s}, sat(m_cnt, CWS));
    chk_bus("bus");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a = 8'h00;
    step(); step();
    rst = 1'b0;
    step();
    chk("lit_rst_q",   {31'd0, drive_q},   32'd0);
    chk("lit_rst_val", {24'd0, last_val},  32'h00);
    chk("lit_rst_cnt", {16'd0, drive_cnt}, 32'd0);

    a = 8'hFF; en = 1'b0;
    step();
    chk("lit_idle_cnt", {16'd0, drive_cnt}, 32'd0);

    a = 8'hAA; en = 1'b1;
    #1 chk("lit_aa_bus", {24'd0, bus}, 32'hAA);
    step();
    chk("lit_aa_val", {24'd0, last_val},  32'hAA);
    chk("lit_aa_q",   {31'd0, drive_q},   32'd1);
    chk("lit_aa_cnt", {16'd0, drive_cnt}, 32'd1);

    a = 8'h55; en = 1'b1;
    #1 chk("lit_55_bus", {24'd0, bus}, 32'h55);
    step(); step(); step();
    chk("lit_55_val",   {24'd0, last_val},    32'h55);
    chk("lit_55_cnt",   {16'd0, drive_cnt},   32'd4);
    chk("lit_sat_cnt",  {30'd0, drive_cnt_s}, 32'd3);

    a = 8'hF0; en = 1'b0;
    step();
    chk("lit_f0_q",   {31'd0, drive_q},   32'd0);
    chk("lit_f0_val", {24'd0, last_val},  32'h55);
    chk("lit_f0_cnt", {16'd0, drive_cnt}, 32'd4);

    // Saturation held with en = 1 on the narrow instance.
    en = 1'b1; a = 8'h3C;
    repeat (5) step();
    chk("lit_sat_hold", {30'd0, drive_cnt_s}, 32'd3);
    chk("lit_3c_cnt",   {16'd0, drive_cnt},   32'd9);

    // Asynchronous reset in the middle of a cycle, clear of the compare slot.
    @(negedge clk);
    #4 rst = 1'b1;
    #1 chk("lit_arst_q",   {31'd0, drive_q},   32'd0);
    chk("lit_arst_val", {24'd0, last_val},  32'h00);
    chk("lit_arst_cnt", {16'd0, drive_cnt}, 32'd0);
    chk_bus("lit_arst_bus");
    step();
    rst = 1'b0;
    step();
    chk("lit_resume_cnt", {16'd0, drive_cnt}, 32'd1);

    // Randomized phase; the per-cycle compare does the checking.
    for (int i = 0; i < 400; i++) begin
      step();
      en = ($urandom_range(0, 3) != 0);
      a  = N'($urandom);
      if ($urandom_range(0, 39) == 0) rst = 1'b1;
      else                            rst = 1'b0;
    end
    rst = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
